traffic_timer: RTL and testbench

TRAFFIC_TIMER -- requirements
Module: traffic_timer

---
 rtl/traffic_timer.sv | 155 +++++++++++++++
 tb/tb_traffic_timer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_timer.sv
// Two-road traffic light controller with per-second countdown digits and a night (flashing yellow) mode.
// All outputs are registered, one cycle behind the state/count they display.
module traffic_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int T_GREEN  = 25,
  parameter int T_YELLOW = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       night,
  output logic [2:0] light1,
  output logic [2:0] light2,
  output logic [4:0] s_ch1,
  output logic [4:0] s_dv1,
  output logic [4:0] s_ch2,
  output logic [4:0] s_dv2
);
  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [6:0]      CNT_G     = 7'(T_GREEN);
  localparam logic [6:0]      CNT_Y     = 7'(T_YELLOW);
  localparam logic [4:0]      RST_CH1   = 5'(T_GREEN / 10);
  localparam logic [4:0]      RST_DV1   = 5'(T_GREEN % 10);
  localparam logic [4:0]      RST_CH2   = 5'((T_GREEN + T_YELLOW) / 10);
  localparam logic [4:0]      RST_DV2   = 5'((T_GREEN + T_YELLOW) % 10);

  typedef enum logic [2:0] {S_G1R2, S_Y1R2, S_R1G2, S_R1Y2, S_NIGHT} state_t;

  state_t        r_state, w_state_next;
  logic [6:0]    r_cnt, w_cnt_next;
  logic [PW-1:0] r_presc, w_presc_next;
  logic          r_sync1, r_sync2;
  logic          r_yel, w_yel_next;
  logic          w_tick;
  logic [2:0]    w_l1, w_l2;
  logic [6:0]    w_v1, w_v2;
  logic [2:0]    r_l1, r_l2;
  logic [4:0]    r_ch1, r_dv1, r_ch2, r_dv2;

  assign w_tick = (r_presc == PRESC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= night;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_G1R2;
      r_cnt   <= CNT_G;
      r_presc <= '0;
      r_yel   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_presc <= w_presc_next;
      r_yel   <= w_yel_next;
    end
  end

  // Night requests win over any phase step due on the same tick.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_yel_next   = r_yel;
    w_presc_next = w_tick ? '0 : r_presc + 1'b1;
    if (r_state != S_NIGHT && r_sync2) begin
      w_state_next = S_NIGHT;
      w_yel_next   = 1'b1;
      w_presc_next = '0;
    end else if (r_state == S_NIGHT) begin
      if (!r_sync2) begin
        w_state_next = S_G1R2;
        w_cnt_next   = CNT_G;
        w_presc_next = '0;
      end else if (w_tick) begin
        w_yel_next = ~r_yel;
      end
    end else if (w_tick) begin
      if (r_cnt > 7'd1) begin
        w_cnt_next = r_cnt - 7'd1;
      end else begin
        case (r_state)
          S_G1R2:  begin w_state_next = S_Y1R2; w_cnt_next = CNT_Y; end
          S_Y1R2:  begin w_state_next = S_R1G2; w_cnt_next = CNT_G; end
          S_R1G2:  begin w_state_next = S_R1Y2; w_cnt_next = CNT_Y; end
          default: begin w_state_next = S_G1R2; w_cnt_next = CNT_G; end
        endcase
      end
    end
  end

  // During green the red road shows the time until it turns green, i.e. green plus yellow remaining.
  always_comb begin
    w_l1 = 3'b001;
    w_l2 = 3'b100;
    w_v1 = r_cnt;
    w_v2 = r_cnt + CNT_Y;
    case (r_state)
      S_G1R2: begin end
      S_Y1R2: begin
        w_l1 = 3'b010;
        w_v2 = r_cnt;
      end
      S_R1G2: begin
        w_l1 = 3'b100;
        w_l2 = 3'b001;
        w_v1 = r_cnt + CNT_Y;
        w_v2 = r_cnt;
      end
      S_R1Y2: begin
        w_l1 = 3'b100;
        w_l2 = 3'b010;
        w_v2 = r_cnt;
      end
      default: begin
        w_l1 = r_yel ? 3'b010 : 3'b000;
        w_l2 = r_yel ? 3'b010 : 3'b000;
        w_v1 = 7'd0;
        w_v2 = 7'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l1  <= 3'b001;
      r_l2  <= 3'b100;
      r_ch1 <= RST_CH1;
      r_dv1 <= RST_DV1;
      r_ch2 <= RST_CH2;
      r_dv2 <= RST_DV2;
    end else begin
      r_l1  <= w_l1;
      r_l2  <= w_l2;
      r_ch1 <= 5'(w_v1 / 7'd10);
      r_dv1 <= 5'(w_v1 % 7'd10);
      r_ch2 <= 5'(w_v2 / 7'd10);
      r_dv2 <= 5'(w_v2 % 7'd10);
    end
  end

  assign light1 = r_l1;
  assign light2 = r_l2;
  assign s_ch1  = r_ch1;
  assign s_dv1  = r_dv1;
  assign s_ch2  = r_ch2;
  assign s_dv2  = r_dv2;

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: two instances (short and default-length phases) checked against an
// elapsed-seconds reference model every cycle, plus directed latency and reset checks.
module tb_traffic_timer;
  localparam int TD0 = 4, G0 = 5,  Y0 = 2;
  localparam int TD1 = 2, G1 = 25, Y1 = 3;

  typedef struct packed {
    logic [2:0] l1;
    logic [2:0] l2;
    logic [4:0] c1;
    logic [4:0] d1;
    logic [4:0] c2;
    logic [4:0] d2;
  } out_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       night;
  logic [2:0] l1_a, l2_a, l1_b, l2_b;
  logic [4:0] c1_a, d1_a, c2_a, d2_a, c1_b, d1_b, c2_b, d2_b;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_timer #(.TICK_DIV(TD0), .T_GREEN(G0), .T_YELLOW(Y0)) u_a (
    .clk(clk), .rst_n(rst_n), .night(night),
    .light1(l1_a), .light2(l2_a),
    .s_ch1(c1_a), .s_dv1(d1_a), .s_ch2(c2_a), .s_dv2(d2_a)
  );

  traffic_timer #(.TICK_DIV(TD1), .T_GREEN(G1), .T_YELLOW(Y1)) u_b (
    .clk(clk), .rst_n(rst_n), .night(night),
    .light1(l1_b), .light2(l2_b),
    .s_ch1(c1_b), .s_dv1(d1_b), .s_ch2(c2_b), .s_dv2(d2_b)
  );

  // Expected display for a given number of whole seconds elapsed since the start of a G1R2 phase.
  function automatic out_t view(int sec, bit nm, bit yel, int g, int y);
    out_t o;
    int v1, v2;
    if (nm) begin
      o.l1 = yel ? 3'b010 : 3'b000;
      o.l2 = o.l1;
      v1 = 0; v2 = 0;
    end else if (sec < g) begin
      o.l1 = 3'b001; o.l2 = 3'b100; v1 = g - sec; v2 = v1 + y;
    end else if (sec < g + y) begin
      o.l1 = 3'b010; o.l2 = 3'b100; v1 = g + y - sec; v2 = v1;
    end else if (sec < 2 * g + y) begin
      o.l1 = 3'b100; o.l2 = 3'b001; v2 = 2 * g + y - sec; v1 = v2 + y;
    end else begin
      o.l1 = 3'b100; o.l2 = 3'b010; v1 = 2 * (g + y) - sec; v2 = v1;
    end
    o.c1 = 5'(v1 / 10); o.d1 = 5'(v1 % 10);
    o.c2 = 5'(v2 / 10); o.d2 = 5'(v2 % 10);
    return o;
  endfunction

  bit nh0, nh1;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nh0 <= 1'b0;
      nh1 <= 1'b0;
    end else begin
      nh0 <= night;
      nh1 <= nh0;
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_model
    localparam int TD  = (gi == 0) ? TD0 : TD1;
    localparam int G   = (gi == 0) ? G0 : G1;
    localparam int Y   = (gi == 0) ? Y0 : Y1;
    localparam int CYC = 2 * (G + Y);
    int   sec, sub;
    bit   nm, yel;
    out_t exp_o;
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sec <= 0; sub <= 0; nm <= 1'b0; yel <= 1'b0;
        exp_o <= view(0, 1'b0, 1'b0, G, Y);
      end else begin
        exp_o <= view(sec, nm, yel, G, Y);
        if (!nm && nh1) begin
          nm <= 1'b1; yel <= 1'b1; sub <= 0;
        end else if (nm && !nh1) begin
          nm <= 1'b0; sec <= 0; sub <= 0;
        end else if (sub == TD - 1) begin
          sub <= 0;
          if (nm) yel <= !yel;
          else    sec <= (sec + 1) % CYC;
        end else begin
          sub <= sub + 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    out_t ga, gb;
    @(negedge clk);
    ga = {l1_a, l2_a, c1_a, d1_a, c2_a, d2_a};
    gb = {l1_b, l2_b, c1_b, d1_b, c2_b, d2_b};
    $display("t=%0t rst_n=%b night=%b a=%h b=%h", $time, rst_n, night, ga, gb);
    chk("model_a", 32'(ga), 32'(g_model[0].exp_o));
    chk("model_b", 32'(gb), 32'(g_model[1].exp_o));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_a_lamps"},  32'({l1_a, l2_a}), 32'h0C);
    chk({tag, "_a_digits"}, 32'({c1_a, d1_a, c2_a, d2_a}), 32'({5'd0, 5'd5, 5'd0, 5'd7}));
    chk({tag, "_b_digits"}, 32'({c1_b, d1_b, c2_b, d2_b}), 32'({5'd2, 5'd5, 5'd2, 5'd8}));
  endtask

  initial begin
    int n, viol, r;
    rst_n = 1'b0;
    night = 1'b0;
    repeat (3) cyc();
    chk_reset_vals("reset_hold");

    // First tick 4 cycles after release, visible one cycle later
    #2 rst_n = 1'b1;
    repeat (4) cyc();
    chk("a_before_tick", 32'({c1_a, d1_a, c2_a, d2_a}), 32'({5'd0, 5'd5, 5'd0, 5'd7}));
    cyc();
    chk("a_after_tick", 32'({c1_a, d1_a, c2_a, d2_a}), 32'({5'd0, 5'd4, 5'd0, 5'd6}));

    n = 0;
    do begin cyc(); n++; end while (!(c1_b == 5'd1 && d1_b == 5'd0) && n < 100);
    chk("b_road1_at10", 32'({c1_b, d1_b}), 32'({5'd1, 5'd0}));
    chk("b_road2_at10", 32'({c2_b, d2_b}), 32'({5'd1, 5'd3}));
    chk("b_lamps_at10", 32'({l1_b, l2_b}), 32'h0C);

    viol = 0;
    repeat (60) begin
      cyc();
      if (!$onehot(l1_a) || !$onehot(l2_a) || (l1_a != 3'b100 && l2_a != 3'b100)) viol++;
    end
    chk("a_lamp_invariant", 32'(viol), 32'd0);

    n = 0;
    do begin cyc(); n++; end while (l1_a != 3'b001 && n < 80);
    chk("a_reach_g1r2", 32'(l1_a), 32'd1);

    #2 night = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (!(l1_a == 3'b010 && l2_a == 3'b010) && n < 8);
    chk("night_entry_latency", 32'(n), 32'd4);
    chk("night_digits", 32'({c1_a, d1_a, c2_a, d2_a}), 32'd0);
    n = 0;
    do begin cyc(); n++; end while (l1_a != 3'b000 && n < 10);
    chk("night_first_toggle", 32'(n), 32'd4);
    chk("night_dark_l2", 32'(l2_a), 32'd0);

    #2 night = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (l1_a != 3'b001 && n < 8);
    chk("night_exit_latency", 32'(n), 32'd4);
    chk("night_exit_digits", 32'({c1_a, d1_a, c2_a, d2_a}), 32'({5'd0, 5'd5, 5'd0, 5'd7}));
    n = 0;
    do begin cyc(); n++; end while (d1_a != 5'd4 && n < 10);
    chk("night_exit_tick", 32'(n), 32'd4);

    n = 0;
    do begin cyc(); n++; end while (l2_a != 3'b010 && n < 80);
    chk("a_reach_r1y2", 32'({l1_a, l2_a}), 32'h22);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_reset");
    cyc();
    #2 rst_n = 1'b1;
    n = 0;
    do begin cyc(); n++; end while (d1_a != 5'd4 && n < 10);
    chk("reset_tick_restart", 32'(n), 32'd5);

    for (int it = 0; it < 50; it++) begin
      r = int'($urandom_range(0, 9));
      #2;
      if (r < 4) begin
        night = ~night;
      end else if (r == 4) begin
        rst_n = 1'b0;
        cyc();
        #2 rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 50)) cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
